// File: rtl/risc_pkg.sv
// risc_pkg: shared FSM encoding and requester IDs for the memory arbiter
package risc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker that remembers the last grantee
module rr_arb2 import risc_pkg::*; (
    input  logic       clk,
    input  logic       rst_,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic       gnt_id,
    output logic       gnt_valid,
    output logic       last_gnt
);
    logic [1:0] live;
    // a tie goes to whoever did not win last; a lone requester always wins
    always_comb begin
        live = req & ~mask;
        gnt_valid = |live;
        gnt_id = (&live) ? ~last_gnt : live[GNT_LDR];
    end
    // remember every grant so the next tie flips
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) last_gnt <= GNT_LDR;
        else if (advance && gnt_valid) last_gnt <= gnt_id;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port memory between the CPU and the loader port
module mem_arbiter import risc_pkg::*; #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_wr,
    input  logic [AWIDTH-1:0] ldr_addr,
    input  logic [DWIDTH-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DWIDTH-1:0] ldr_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);
    state_t            state, next_state;
    logic              gnt, gnt_valid, last_gnt, load, op_wr, rd_done;
    logic [1:0]        mask;
    logic [DWIDTH-1:0] cpu_rdata_q, ldr_rdata_q;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_      (rst_),
        .req       ({ldr_req, cpu_req}),
        .mask      (mask),
        .advance   (load),
        .gnt_id    (gnt),
        .gnt_valid (gnt_valid),
        .last_gnt  (last_gnt)
    );

    // next state and handshake outputs; in DONE the finishing winner is masked
    // so only the other side can be granted straight into ACCESS
    always_comb begin
        mask = 2'b00;
        if (state == DONE) mask[last_gnt] = 1'b1;
        load = gnt_valid && (state == IDLE || state == DONE);
        next_state = IDLE;
        case (state)
            IDLE:    next_state = load ? ACCESS : IDLE;
            ACCESS:  next_state = DONE;
            DONE:    next_state = load ? ACCESS : IDLE;
            default: next_state = IDLE;
        endcase
        cpu_ack = (state == DONE) && (last_gnt == GNT_CPU);
        ldr_ack = (state == DONE) && (last_gnt == GNT_LDR);
        rd_done = (state == DONE) && !op_wr;
        cpu_rdata = (cpu_ack && rd_done) ? mem_rdata : cpu_rdata_q;
        ldr_rdata = (ldr_ack && rd_done) ? mem_rdata : ldr_rdata_q;
        cpu_stall = cpu_req && !cpu_ack;
        busy = state != IDLE;
        gnt_id = last_gnt;
    end

    // state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else state <= next_state;
    end

    // capture the winner's request onto the memory bus; strobe lasts one cycle
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            op_wr     <= 1'b0;
        end else begin
            mem_cs <= load;
            mem_we <= load && (gnt ? ldr_wr : cpu_wr);
            if (load) begin
                mem_addr  <= gnt ? ldr_addr : cpu_addr;
                mem_wdata <= gnt ? ldr_wdata : cpu_wdata;
                op_wr     <= gnt ? ldr_wr : cpu_wr;
            end
        end
    end

    // hold read data per requester; the bypass above makes it valid with ack
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (cpu_ack && rd_done) cpu_rdata_q <= mem_rdata;
            if (ldr_ack && rd_done) ldr_rdata_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a synchronous memory model
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       cpu_req = 1'b0, cpu_wr = 1'b0, ldr_req = 1'b0, ldr_wr = 1'b0;
    logic [4:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
    logic [7:0] cpu_wdata = '0, ldr_wdata = '0, mem_wdata, cpu_rdata, ldr_rdata;
    logic [7:0] mem_rdata = '0;
    logic       cpu_ack, cpu_stall, ldr_ack, mem_cs, mem_we, busy, gnt_id;
    logic [7:0] mem [32];
    int compared = 0, mismatched = 0;
    int cpu_acks = 0, ldr_acks = 0, we_cnt = 0, both_acks = 0;
    int c0, l0, w0;

    mem_arbiter dut (
        .clk(clk), .rst_(rst_),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (cpu_ack) cpu_acks++;
        if (ldr_ack) ldr_acks++;
        if (cpu_ack && ldr_ack) both_acks++;
        if (mem_we) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[3] = 8'hA5;
        step(); step();
        chk("rst_cs", mem_cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 1);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        rst_ = 1'b1;
        step();
        // CPU read of 0x03
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
        #1 chk("rd_stall_n", cpu_stall, 1);
        step();
        chk("rd_cs", mem_cs, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 5'h03);
        chk("rd_gnt", gnt_id, 0);
        chk("rd_ack_early", cpu_ack, 0);
        chk("rd_stall_n1", cpu_stall, 1);
        chk("rd_busy", busy, 1);
        step();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_rdata, 8'hA5);
        chk("rd_cs_off", mem_cs, 0);
        chk("rd_stall_off", cpu_stall, 0);
        cpu_req = 0;
        step();
        chk("rd_idle", busy, 0);
        chk("rd_ack_off", cpu_ack, 0);
        chk("rd_hold", cpu_rdata, 8'hA5);
        // loader write 0x3C to 0x1F, then CPU read back
        w0 = we_cnt;
        ldr_req = 1; ldr_wr = 1; ldr_addr = 5'h1F; ldr_wdata = 8'h3C;
        step();
        chk("wr_cs", mem_cs, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 5'h1F);
        chk("wr_data", mem_wdata, 8'h3C);
        chk("wr_gnt", gnt_id, 1);
        step();
        chk("wr_ack", ldr_ack, 1);
        chk("wr_rdata_kept", ldr_rdata, 0);
        chk("wr_we_off", mem_we, 0);
        ldr_req = 0; ldr_wr = 0;
        cpu_req = 1; cpu_addr = 5'h1F;
        step(); step();
        chk("rb_ack", cpu_ack, 1);
        chk("rb_data", cpu_rdata, 8'h3C);
        chk("rb_we_once", we_cnt - w0, 1);
        cpu_req = 0;
        step();
        // reset in the middle of an access
        cpu_req = 1; cpu_addr = 5'h03;
        step();
        chk("mr_cs", mem_cs, 1);
        c0 = cpu_acks;
        rst_ = 0; cpu_req = 0;
        #1;
        chk("mr_cs_off", mem_cs, 0);
        chk("mr_acks", {cpu_ack, ldr_ack}, 0);
        chk("mr_busy", busy, 0);
        chk("mr_gnt", gnt_id, 1);
        step();
        chk("mr_cs_hold", mem_cs, 0);
        chk("mr_no_ack", cpu_acks - c0, 0);
        rst_ = 1;
        step();
        // both request out of reset: CPU first, loader straight from DONE
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
        ldr_req = 1; ldr_wr = 0; ldr_addr = 5'h1F;
        step();
        chk("bo_gnt0", gnt_id, 0);
        chk("bo_addr0", mem_addr, 5'h03);
        step();
        chk("bo_ack0", {cpu_ack, ldr_ack}, 2'b10);
        chk("bo_data0", cpu_rdata, 8'hA5);
        cpu_req = 0;
        step();
        chk("bo_cs1", mem_cs, 1);
        chk("bo_gnt1", gnt_id, 1);
        chk("bo_addr1", mem_addr, 5'h1F);
        step();
        chk("bo_ack1", {cpu_ack, ldr_ack}, 2'b01);
        chk("bo_data1", ldr_rdata, 8'h3C);
        ldr_req = 0;
        step();
        chk("bo_idle", busy, 0);
        // both held continuously: six alternating grants
        c0 = cpu_acks; l0 = ldr_acks;
        cpu_req = 1; ldr_req = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("alt_gnt%0d", k), gnt_id, k % 2);
            step();
            chk($sformatf("alt_ack%0d", k), {cpu_ack, ldr_ack}, (k % 2) ? 2'b01 : 2'b10);
        end
        cpu_req = 0; ldr_req = 0;
        step();
        chk("alt_idle", busy, 0);
        chk("alt_cpu_cnt", cpu_acks - c0, 3);
        chk("alt_ldr_cnt", ldr_acks - l0, 3);
        // loader drops request during ACCESS
        l0 = ldr_acks;
        ldr_req = 1; ldr_addr = 5'h03;
        step();
        chk("dr_gnt", gnt_id, 1);
        chk("dr_cs", mem_cs, 1);
        ldr_req = 0;
        step();
        chk("dr_ack", ldr_ack, 1);
        chk("dr_data", ldr_rdata, 8'hA5);
        step();
        chk("dr_idle", busy, 0);
        chk("dr_ack_off", ldr_ack, 0);
        step();
        chk("dr_once", ldr_acks - l0, 1);
        chk("never_both", both_acks, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
